// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: 2-flop synchroniser, mid-bit sampling FSM, error flags.
// Optional feature: define RX_PARITY_CHECK_EN to drive erro_paridade from the odd-parity check.
module rx_serial_7o1 #(
  parameter int unsigned M = 5208,
  parameter int unsigned N = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_parada,
  output logic       db_dado_serial,
  output logic       db_tick,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StStart  = 4'd1,
    StData   = 4'd2,
    StParity = 4'd3,
    StStop   = 4'd4,
    StStore  = 4'd5
  } state_t;

  localparam logic [N-1:0] HalfCnt = N'(M / 2 - 1);
  localparam logic [N-1:0] FullCnt = N'(M - 1);

  state_t       state_q, state_d;
  logic         sync1_q, sync2_q;
  logic [N-1:0] cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [6:0]   sr_q, sr_d;
  logic [6:0]   data_q, data_d;
  logic         ferr_q, ferr_d;
  logic         line;

  assign line = sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= dado_serial;
      sync2_q <= sync1_q;
    end
  end

`ifdef RX_PARITY_CHECK_EN
  logic par_q, par_d;
  logic perr_q, perr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign erro_paridade = perr_q;
`else
  assign erro_paridade = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    db_tick = 1'b0;
`ifdef RX_PARITY_CHECK_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!line) begin
          state_d = StStart;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          db_tick = 1'b1;
          cnt_d   = '0;
          state_d = line ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          db_tick = 1'b1;
          cnt_d   = '0;
          sr_d    = {line, sr_q[6:1]};  // LSB arrives first, ends up in bit 0
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd6) begin
            state_d = StParity;
            bit_d   = '0;
          end
        end
      end
      StParity: begin
        if (cnt_q == FullCnt) begin
          db_tick = 1'b1;
          cnt_d   = '0;
          state_d = StStop;
`ifdef RX_PARITY_CHECK_EN
          par_d   = line;
`endif
        end
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          db_tick = 1'b1;
          cnt_d   = '0;
          state_d = StStore;
          // Results latch on entry to STORE so they are valid while pronto is high.
          data_d  = sr_q;
          ferr_d  = ~line;
`ifdef RX_PARITY_CHECK_EN
          perr_d  = ~(^{sr_q, par_q});
`endif
        end
      end
      StStore: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign dados_ascii    = data_q;
  assign erro_parada    = ferr_q;
  assign pronto         = (state_q == StStore);
  assign db_dado_serial = sync2_q;
  assign db_estado      = state_q;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Randomised self-checking bench for rx_serial_7o1 against a frame-level reference model.
module tb_rx_serial_7o1;

  localparam int unsigned M      = 16;
  localparam int unsigned N      = 5;
  localparam int          LatExp = M / 2 + 9 * M + 1 + 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       dado_serial;
  logic [6:0] dados_ascii;
  logic       pronto, erro_paridade, erro_parada;
  logic       db_dado_serial, db_tick;
  logic [3:0] db_estado;

  rx_serial_7o1 #(.M(M), .N(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .dado_serial   (dado_serial),
    .dados_ascii   (dados_ascii),
    .pronto        (pronto),
    .erro_paridade (erro_paridade),
    .erro_parada   (erro_parada),
    .db_dado_serial(db_dado_serial),
    .db_tick       (db_tick),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rx_t;

  rx_t  got_q[$];
  int   cyc       = 0;
  int   tick_cnt  = 0;
  logic saw_start = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  // Model of the last stored result.
  logic [6:0] m_data = '0;
  logic       m_pe   = 1'b0;
  logic       m_fe   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pronto) got_q.push_back('{d: dados_ascii, pe: erro_paridade, fe: erro_parada, cyc: cyc});
    if (db_tick) tick_cnt++;
    if (db_estado == 4'd1) saw_start = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_perr(input logic [6:0] d, input logic p);
`ifdef RX_PARITY_CHECK_EN
    return ($countones({d, p}) % 2) == 0;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one full frame starting on a falling clock edge; returns its start cycle and tick base.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s,
                            output int start, output int tbase);
    logic [9:0] bits;
    bits  = {s, p, d, 1'b0};
    start = cyc;
    tbase = tick_cnt;
    for (int i = 0; i < 10; i++) begin
      dado_serial = bits[i];
      repeat (M) @(negedge clock);
    end
    dado_serial = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [6:0] d, input logic p,
                              input logic s, input int start, input int tbase);
    rx_t r;
    m_data = d;
    m_pe   = model_perr(d, p);
    m_fe   = ~s;
    check_eq({tag, "_pronto_count"}, got_q.size(), 1);
    check_eq({tag, "_ticks"}, tick_cnt - tbase, 10);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      check_eq({tag, "_data"}, {25'd0, r.d}, {25'd0, m_data});
      check_eq({tag, "_perr"}, {31'd0, r.pe}, {31'd0, m_pe});
      check_eq({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, m_fe});
      check_eq({tag, "_latency"}, r.cyc - start, LatExp);
    end
    got_q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [6:0] d, input logic p, input logic s);
    int start, tbase;
    send_frame(d, p, s, start, tbase);
    expect_frame(tag, d, p, s, start, tbase);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_data"}, {25'd0, dados_ascii}, {25'd0, m_data});
    check_eq({tag, "_perr"}, {31'd0, erro_paridade}, {31'd0, m_pe});
    check_eq({tag, "_ferr"}, {31'd0, erro_parada}, {31'd0, m_fe});
  endtask

  initial begin
    logic [6:0] rd;
    logic       rp, rs;
    reset       = 1'b1;
    dado_serial = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs("reset");
    check_eq("reset_pronto", {31'd0, pronto}, 0);
    check_eq("reset_state", {28'd0, db_estado}, 0);
    check_eq("reset_sync", {31'd0, db_dado_serial}, 1);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    run_frame("frame_A", 7'h41, 1'b1, 1'b1);
    repeat (8) @(negedge clock);

    // Reset in the middle of the data bits.
    dado_serial = 1'b0;
    repeat (M * 3) @(negedge clock);
    check_eq("mid_state_data", {28'd0, db_estado}, 2);
    reset = 1'b1;
    #1;
    m_data = '0; m_pe = 1'b0; m_fe = 1'b0;
    check_eq("rst_state", {28'd0, db_estado}, 0);
    check_outputs("rst_mid");
    @(negedge clock);
    dado_serial = 1'b1;
    reset = 1'b0;
    repeat (M * 12) @(negedge clock);
    check_eq("rst_no_pronto", got_q.size(), 0);
    got_q.delete();

    run_frame("frame_C_badpar", 7'h43, 1'b1, 1'b1);
    repeat (8) @(negedge clock);

    run_frame("frame_55_badstop", 7'h55, 1'b1, 1'b0);
    repeat (24) @(negedge clock);
    check_eq("badstop_no_extra", got_q.size(), 0);
    got_q.delete();
    run_frame("frame_after_badstop", 7'h12, 1'b1, 1'b1);
    repeat (8) @(negedge clock);

    // Short low glitch on an idle line.
    saw_start = 1'b0;
    dado_serial = 1'b0;
    repeat (4) @(negedge clock);
    dado_serial = 1'b1;
    repeat (30) @(negedge clock);
    check_eq("glitch_saw_start", {31'd0, saw_start}, 1);
    check_eq("glitch_state", {28'd0, db_estado}, 0);
    check_eq("glitch_no_pronto", got_q.size(), 0);
    check_outputs("glitch_hold");
    got_q.delete();

    run_frame("b2b_30", 7'h30, 1'b1, 1'b1);
    run_frame("b2b_7F", 7'h7F, 1'b0, 1'b1);
    repeat (8) @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      rd = 7'($urandom_range(0, 127));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rand%0d", i), rd, rp, rs);
      repeat (24) @(negedge clock);
      check_eq($sformatf("rand%0d_quiet", i), got_q.size(), 0);
      got_q.delete();
      check_outputs($sformatf("rand%0d_hold", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
